mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Two-requester round-robin arbiter that owns the select line of a shared 2:1 datapath mux.
//  Requesters A and B each raise a level request.
//  The block grants one requester at a time and steers that requester's data to y.
//  A hold counter forces a hand-off, so neither side can starve the other.
//  It sits between two producers and a single shared consumer path.
// PARAMETERS
//  WIDTH     1   data width of a, b, y
//  MAX_HOLD  8   max cycles a grant is kept while the other side is requesting (>=1)
//  HOLD_W    $clog2(MAX_HOLD+1)   hold counter width (derived; not overridden)
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      asynchronous active-low reset
//  req_a  in   1      level request from A; held until A has finished
//  req_b  in   1      level request from B
//  a      in   WIDTH  data from A
//  b      in   WIDTH  data from B
//  gnt_a  out  1      A owns the path (registered)
//  gnt_b  out  1      B owns the path (registered)
//  s      out  1      mux select: 0 -> y=a, 1 -> y=b (registered)
//  y      out  WIDTH  selected data (combinational from s, a, b)
//  busy   out  1      gnt_a | gnt_b
// BEHAVIOUR
//  Clock and reset
//  - One clock.
//  - Reset is asynchronous and active-low.
//  - On rst_n=0: state=IDLE, gnt_a=gnt_b=0, busy=0, s=0 (so y=a), last=B, hold_cnt=0.
//  FSM states: IDLE, GNT_A, GNT_B. Grants are one-hot or zero; both high is illegal.
//  Latency
//  - Request to grant: 1 cycle (grant visible the cycle after req is sampled high).
//  - s changes in the same cycle as the grant; y follows s combinationally.
//  IDLE transitions
//  - Only req_a -> GNT_A. Only req_b -> GNT_B.
//  - Both requesting -> grant the side that is not `last` (after reset, A wins first).
//  - Neither requesting -> stay in IDLE.
//  GNT_A transitions (GNT_B is symmetric)
//  - req_a dropped and req_b high -> GNT_B directly; no IDLE bubble.
//  - req_a dropped and req_b low -> IDLE.
//  - req_a still high and req_b high -> hold_cnt increments each cycle.
//    When hold_cnt==MAX_HOLD-1 the next state is GNT_B (forced pre-emption).
//  - req_b low -> hold_cnt is cleared to 0 (counts consecutive contention cycles only).
//  Grant bookkeeping
//  - `last` is updated to the granted side on every entry to a GNT state.
//  - hold_cnt clears on every state change.
//  In IDLE, s holds its previous value (no glitch on y while idle).
//  Simultaneous events
//  - Release and pre-emption in the same cycle: treated as a release; the result is the same target.
//  - Reset mid-grant: grants drop immediately (asynchronous).
//  hold_cnt saturates logically; it never wraps past MAX_HOLD-1.
// STRUCTURE
//  Shared package mux_arb_pkg: state typedef {IDLE, GNT_A, GNT_B}, SEL_A=1'b0, SEL_B=1'b1.
//  Sub-module mux2_data: WIDTH-parameterised combinational 2:1 mux (a, b, s -> y).
//  FSM, `last` register and hold counter live in the top module.
// TESTING (MAX_HOLD=4, WIDTH=4, a=4'hA, b=4'h5)
//  1. Reset mid-operation:
//     - assert rst_n=0 while gnt_b=1 -> gnt_a=gnt_b=0 and s=0 immediately, y=4'hA.
//     - after release, req_a=1 -> gnt_a=1 next edge.
//  2. Single requester: req_a=1 at edge 1, drop at edge 5.
//     - gnt_a=1 from edge 2 through edge 5, IDLE at edge 6.
//     - s stays 0 throughout; y=4'hA.
//  3. Tie after reset: req_a=req_b=1 together -> A granted first.
//     - after 4 contention cycles, forced to gnt_b with s=1 and y=4'h5.
//     - B then held 4 cycles, then back to A (alternation).
//  4. Direct hand-off: gnt_a=1, req_b=1, req_a drops.
//     - next edge gnt_b=1, gnt_a=0; busy never drops; no IDLE cycle.
//  5. Late contention: req_a held 10 cycles, req_b rises at cycle 7.
//     - pre-empt at cycle 7+4, not earlier.
//     - hold_cnt only counts contention cycles.
//  6. Assertions checked every cycle:
//     - !(gnt_a & gnt_b); s==gnt_b whenever busy; y==(s?b:a).

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// The select encoding also identifies a side, and `last` is stored that way.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_rr_arbiter_data.sv
// Combinational 2:1 data mux steered by the arbiter's registered select.
module mux2_data
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = (s == SEL_B) ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two level requesters that owns a shared 2:1 mux select.
// A hold counter bounds how long one side keeps the path while the other waits.
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int WIDTH    = 1,
    parameter  int MAX_HOLD = 8,
    localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             s,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_reg, state_next;
    logic              last_reg, last_next;
    logic              s_reg, s_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        s_next        = s_reg;
        hold_cnt_next = hold_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (req_a && (!req_b || last_reg == SEL_B))
                    state_next = GNT_A;
                else if (req_b)
                    state_next = GNT_B;
            end
            GNT_A: begin
                // A release wins over pre-emption; both land on the same target.
                if (!req_a)
                    state_next = req_b ? GNT_B : IDLE;
                else if (req_b) begin
                    if (hold_cnt_reg == HOLD_LAST)
                        state_next = GNT_B;
                    else
                        hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end else
                    hold_cnt_next = '0;
            end
            GNT_B: begin
                if (!req_b)
                    state_next = req_a ? GNT_A : IDLE;
                else if (req_a) begin
                    if (hold_cnt_reg == HOLD_LAST)
                        state_next = GNT_A;
                    else
                        hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end else
                    hold_cnt_next = '0;
            end
            default: state_next = IDLE;
        endcase

        // Select only moves on grant entry, so y stays put while idle.
        if (state_next != state_reg) begin
            hold_cnt_next = '0;
            if (state_next == GNT_A) begin
                last_next = SEL_A;
                s_next    = SEL_A;
            end else if (state_next == GNT_B) begin
                last_next = SEL_B;
                s_next    = SEL_B;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            last_reg     <= SEL_B;
            s_reg        <= SEL_A;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            s_reg        <= s_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign gnt_a = (state_reg == GNT_A);
    assign gnt_b = (state_reg == GNT_B);
    assign busy  = gnt_a | gnt_b;
    assign s     = s_reg;

    mux2_data #(
        .WIDTH(WIDTH)
    ) u_data (
        .a(a),
        .b(b),
        .s(s_reg),
        .y(y)
    );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: directed scenarios plus random requests,
// checked against an ownership-level model of the round-robin rules.
module tb_mux2_rr_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_a, req_b;
    logic [WIDTH-1:0] a, b;
    logic             gnt_a, gnt_b, s, busy;
    logic [WIDTH-1:0] y;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             ga;
        logic             gb;
        logic             sel;
        logic [WIDTH-1:0] yv;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];

    // Model: owner 0 = nobody, 1 = A, 2 = B; last is the side most recently granted.
    int   m_owner;
    int   m_last;
    int   m_streak;
    logic m_sel;
    int   cyc_no = 0;

    mux2_rr_arbiter #(
        .WIDTH(WIDTH),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_a(req_a),
        .req_b(req_b),
        .a(a),
        .b(b),
        .gnt_a(gnt_a),
        .gnt_b(gnt_b),
        .s(s),
        .y(y),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner  = 0;
        m_last   = 2;
        m_streak = 0;
        m_sel    = 1'b0;
    endfunction

    // Ownership rules: hold while requesting, yield immediately on release, and yield
    // to a waiting other side once it has waited MAX_HOLD consecutive cycles.
    function automatic void model_step(input logic ra, input logic rb);
        logic want [3];
        int   other;
        want[0] = 1'b0;
        want[1] = ra;
        want[2] = rb;
        if (m_owner == 0) begin
            if (ra && rb) m_owner = 3 - m_last;
            else if (ra)  m_owner = 1;
            else if (rb)  m_owner = 2;
            m_streak = 0;
            if (m_owner != 0) m_last = m_owner;
        end else begin
            other = 3 - m_owner;
            if (!want[m_owner]) begin
                m_owner  = want[other] ? other : 0;
                m_streak = 0;
                if (m_owner != 0) m_last = m_owner;
            end else if (want[other]) begin
                m_streak++;
                if (m_streak >= MAX_HOLD) begin
                    m_owner  = other;
                    m_last   = other;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
        end
        if (m_owner == 1) m_sel = 1'b0;
        else if (m_owner == 2) m_sel = 1'b1;
    endfunction

    // One transaction: drive inputs at negedge, step the model on the sampling edge,
    // queue the expected post-edge outputs.
    task automatic cycle(input logic ra, input logic rb,
                         input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        exp_t e;
        @(negedge clk);
        req_a = ra;
        req_b = rb;
        a     = da;
        b     = db;
        @(posedge clk);
        model_step(ra, rb);
        cyc_no++;
        e.ga  = (m_owner == 1);
        e.gb  = (m_owner == 2);
        e.sel = m_sel;
        e.yv  = m_sel ? db : da;
        e.cyc = cyc_no;
        exp_q.push_back(e);
    endtask

    // Monitor: compares each registered response just after the edge that produced it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("cyc %0d req_a=%b req_b=%b -> gnt_a=%b gnt_b=%b s=%b y=%h",
                         e.cyc, req_a, req_b, gnt_a, gnt_b, s, y);
                check_bit("gnt_a", gnt_a, e.ga);
                check_bit("gnt_b", gnt_b, e.gb);
                check_bit("s", s, e.sel);
                check_vec("y", y, e.yv);
                check_bit("busy", busy, e.ga | e.gb);
            end
            if (rst_n) begin
                check_bit("one_hot_grant", gnt_a & gnt_b, 1'b0);
                if (busy) check_bit("s_tracks_gnt_b", s, gnt_b);
                check_vec("y_follows_s", y, s ? b : a);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        a     = 4'hA;
        b     = 4'h5;
        model_reset();
        repeat (2) @(negedge clk);
        check_bit("reset_gnt_a", gnt_a, 1'b0);
        check_bit("reset_gnt_b", gnt_b, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_s", s, 1'b0);
        check_vec("reset_y", y, 4'hA);
        rst_n = 1'b1;

        // Tie after reset: A first, forced hand-offs alternate every MAX_HOLD cycles.
        repeat (14) cycle(1'b1, 1'b1, 4'hA, 4'h5);
        repeat (2) cycle(1'b0, 1'b0, 4'hA, 4'h5);

        // Single requester: A holds indefinitely without contention.
        repeat (4) cycle(1'b1, 1'b0, 4'hA, 4'h5);
        repeat (2) cycle(1'b0, 1'b0, 4'hA, 4'h5);

        // Direct hand-off with no idle bubble.
        repeat (2) cycle(1'b1, 1'b0, 4'hA, 4'h5);
        cycle(1'b1, 1'b1, 4'hA, 4'h5);
        repeat (2) cycle(1'b0, 1'b1, 4'hA, 4'h5);

        // Late contention: hold counter only counts cycles where both request.
        repeat (2) cycle(1'b0, 1'b0, 4'hA, 4'h5);
        repeat (6) cycle(1'b1, 1'b0, 4'hA, 4'h5);
        repeat (6) cycle(1'b1, 1'b1, 4'hA, 4'h5);
        repeat (2) cycle(1'b0, 1'b0, 4'hA, 4'h5);

        // Reset mid-grant: B owns the path, then rst_n drops between edges.
        repeat (2) cycle(1'b0, 1'b1, 4'hA, 4'h5);
        #3;
        rst_n = 1'b0;
        #1;
        check_bit("async_rst_gnt_a", gnt_a, 1'b0);
        check_bit("async_rst_gnt_b", gnt_b, 1'b0);
        check_bit("async_rst_s", s, 1'b0);
        check_vec("async_rst_y", y, 4'hA);
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) cycle(1'b1, 1'b0, 4'hA, 4'h5);
        cycle(1'b0, 1'b0, 4'hA, 4'h5);

        // Random phase with shifting request densities and random data.
        for (int i = 0; i < 1500; i++) begin
            int dens;
            dens = (i / 100) % 4;
            cycle($urandom_range(0, 3) <= dens, $urandom_range(0, 3) <= dens,
                  WIDTH'($urandom), WIDTH'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
